// File: rtl/uart_tx_framer_pkg.sv
// Shared UART framing definitions: FSM state encoding, frame-bit levels and
// the baud divisor calculation used by the transmitter.
package uart_tx_framer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    // Rounded-to-nearest clocks per bit.
    function automatic int calc_baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled and flags the last
// clock of each bit period with bit_tick.
module uart_baud_gen #(
    parameter int BAUD_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);
    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt;

    assign bit_tick = enable && (cnt == CW'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= bit_tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: one byte per valid/ready handshake framed as start, 8 data
// bits LSB first, optional parity and 1 or 2 stop bits on a registered line.
module uart_tx_framer
    import uart_tx_framer_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       uart_tx
);
    localparam int BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_framer: STOP_BITS must be 1 or 2");
    end
    if (BAUD_DIV < 2) begin : g_bad_div
        $error("uart_tx_framer: BAUD_DIV must be at least 2");
    end

    state_t     state;
    logic [7:0] shift_reg;
    logic [2:0] bit_idx;
    logic       stop_idx;
    logic       parity_bit;
    logic       bit_tick;
    logic       accept;

    assign tx_ready = (state == IDLE);
    assign accept   = tx_valid && tx_ready;

    uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .enable   (tx_busy),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            parity_bit <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            uart_tx    <= IDLE_LVL;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: if (tx_valid) begin
                    shift_reg  <= data_in;
                    parity_bit <= (^data_in) ^ (PARITY_ODD != 0);
                    bit_idx    <= '0;
                    stop_idx   <= 1'b0;
                    tx_busy    <= 1'b1;
                    uart_tx    <= START_LVL;
                    state      <= START;
                end
                START: if (bit_tick) begin
                    uart_tx <= shift_reg[0];
                    state   <= DATA;
                end
                // The line is registered, so the next bit is taken from
                // shift_reg[1] in the same edge that shifts it down to [0].
                DATA: if (bit_tick) begin
                    if (bit_idx == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            uart_tx <= parity_bit;
                            state   <= PARITY;
                        end else begin
                            uart_tx <= STOP_LVL;
                            state   <= STOP;
                        end
                    end else begin
                        bit_idx   <= bit_idx + 3'd1;
                        shift_reg <= shift_reg >> 1;
                        uart_tx   <= shift_reg[1];
                    end
                end
                PARITY: if (bit_tick) begin
                    uart_tx <= STOP_LVL;
                    state   <= STOP;
                end
                STOP: if (bit_tick) begin
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        stop_idx <= 1'b1;
                    end
                end
                default: begin
                    tx_busy <= 1'b0;
                    uart_tx <= IDLE_LVL;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four framing variants checked each cycle against a
// frame-bit/cycle-count reference model, plus directed and random traffic.
module tb_uart_tx_framer;
    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [3:0] valid = '0;
    logic [3:0] line, busy, ready, done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_ctr = 0;
    int done_seen [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

    // 0: no parity/1 stop, 1: even/1 stop, 2: odd/1 stop, 3: no parity/2 stop
    uart_tx_framer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx_busy(busy[0]), .tx_done(done[0]), .uart_tx(line[0]));
    uart_tx_framer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx_busy(busy[1]), .tx_done(done[1]), .uart_tx(line[1]));
    uart_tx_framer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx_busy(busy[2]), .tx_done(done[2]), .uart_tx(line[2]));
    uart_tx_framer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .tx_valid(valid[3]),
        .tx_ready(ready[3]), .tx_busy(busy[3]), .tx_done(done[3]), .uart_tx(line[3]));

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int par_en(input int k);  return (k == 1 || k == 2) ? 1 : 0; endfunction
    function automatic int par_odd(input int k); return (k == 2) ? 1 : 0; endfunction
    function automatic int n_stop(input int k);  return (k == 3) ? 2 : 1; endfunction
    function automatic int frame_clks(input int k);
        return (1 + 8 + par_en(k) + n_stop(k)) * DIV;
    endfunction

    // Bit list of a whole frame, index 0 = start bit.
    function automatic logic [11:0] build_frame(input int k, input logic [7:0] b);
        logic [11:0] f;
        int n;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = b[i];
        n = 9;
        if (par_en(k) != 0) begin
            f[n] = (^b) ^ (par_odd(k) != 0);
            n++;
        end
        return f;
    endfunction

    // Reference model: which frame is on the line and how many clocks into it.
    logic        m_act  [4];
    int          m_cyc  [4];
    logic [11:0] m_frm  [4];
    logic        m_done [4];

    initial for (int k = 0; k < 4; k++) begin
        m_act[k] = 0; m_cyc[k] = 0; m_frm[k] = '1; m_done[k] = 0; done_seen[k] = 0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            logic exp_line;
            logic nd;
            if (!rst_n) begin
                m_act[k] = 0;
                m_done[k] = 0;
            end
            exp_line = m_act[k] ? m_frm[k][m_cyc[k] / DIV] : 1'b1;
            chk($sformatf("line%0d", k), int'(line[k]), int'(exp_line));
            chk($sformatf("busy%0d", k), int'(busy[k]), int'(m_act[k]));
            chk($sformatf("ready%0d", k), int'(ready[k]), int'(!m_act[k]));
            chk($sformatf("done%0d", k), int'(done[k]), int'(m_done[k]));
            if (done[k]) done_seen[k]++;
            nd = 0;
            if (rst_n) begin
                if (m_act[k]) begin
                    if (m_cyc[k] == frame_clks(k) - 1) begin
                        m_act[k] = 0;
                        nd = 1;
                    end else begin
                        m_cyc[k]++;
                    end
                end else if (valid[k]) begin
                    m_act[k] = 1;
                    m_cyc[k] = 0;
                    m_frm[k] = build_frame(k, data_in);
                end
            end
            m_done[k] = nd;
        end
    end

    // Raises valid, waits for the accepting edge, then drops valid.
    task automatic send(input int k, input logic [7:0] b);
        int n;
        @(posedge clk); #1;
        valid[k] = 1'b1;
        data_in = b;
        n = 0;
        while (!ready[k] && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready[k] && n < 2000);
        if (n >= 2000) chk("idle_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rx;
        int t0, t1, d3_before;

        // Reset held with tx_valid toggling
        repeat (20) begin
            @(posedge clk); #1;
            valid = 4'($urandom);
            data_in = 8'($urandom);
        end
        @(negedge clk);
        chk("rst_line", int'(line), 'hF);
        chk("rst_ready", int'(ready), 'hF);
        @(posedge clk); #1;
        valid = '0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 0x55 on the basic framer, decoded at bit centres
        send(0, 8'h55);
        repeat (5) @(negedge clk);
        chk("rx_start", int'(line[0]), 0);
        rx = '0;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            rx[i] = line[0];
        end
        repeat (DIV) @(negedge clk);
        chk("rx_stop", int'(line[0]), 1);
        chk("rx_byte", int'(rx), 'h55);
        wait_idle(0);

        // Parity sense: parity bit sits in bit slot 9
        send(1, 8'h03);
        repeat (9 * DIV + 5) @(negedge clk);
        chk("par_even_03", int'(line[1]), 0);
        wait_idle(1);
        send(1, 8'h07);
        repeat (9 * DIV + 5) @(negedge clk);
        chk("par_even_07", int'(line[1]), 1);
        wait_idle(1);
        send(2, 8'h07);
        repeat (9 * DIV + 5) @(negedge clk);
        chk("par_odd_07", int'(line[2]), 0);
        wait_idle(2);

        // Two stop bits, valid held across two frames
        d3_before = done_seen[3];
        @(posedge clk); #1;
        valid[3] = 1'b1;
        data_in = 8'hA5;
        while (!ready[3]) @(negedge clk);
        t0 = cyc_ctr;
        @(posedge clk); #1;
        data_in = 8'h3C;
        @(negedge clk);
        while (!ready[3] && cyc_ctr - t0 < 500) @(negedge clk);
        t1 = cyc_ctr;
        @(posedge clk); #1;
        valid[3] = 1'b0;
        chk("b2b_period", t1 - t0, 111);
        wait_idle(3);
        chk("b2b_dones", done_seen[3] - d3_before, 2);

        // Mid-frame valid with toggling data is ignored
        send(0, 8'h81);
        @(posedge clk); #1;
        valid[0] = 1'b1;
        for (int i = 0; i < 70; i++) begin
            data_in = (i % 2 == 0) ? 8'hFF : 8'($urandom);
            @(posedge clk); #1;
        end
        valid[0] = 1'b0;
        wait_idle(0);

        // Reset during data bit 4 of 0x00
        send(0, 8'h00);
        repeat (54) @(posedge clk);
        #1;
        chk("pre_rst_line", int'(line[0]), 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_line", int'(line[0]), 1);
        chk("async_rst_busy", int'(busy[0]), 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(0, 8'hC3);
        wait_idle(0);

        // Random traffic, sometimes with mid-frame noise or held valid
        for (int it = 0; it < 30; it++) begin
            int k;
            int mode;
            k = int'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 2));
            send(k, 8'($urandom));
            if (mode == 1) begin
                valid[k] = 1'b1;
                repeat (int'($urandom_range(5, 60))) begin
                    data_in = 8'($urandom);
                    @(posedge clk); #1;
                end
                valid[k] = 1'b0;
            end else if (mode == 2) begin
                valid[k] = 1'b1;
                data_in = 8'($urandom);
                while (!ready[k]) @(negedge clk);
                @(posedge clk); #1;
                valid[k] = 1'b0;
            end
            wait_idle(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
